// File: rtl/tag_resolver.sv
// Multiple-response resolver: snapshots the CAPP tag register and hands out
// the set tag indices lowest-first on a valid/ready port with a one-hot select.
module tag_resolver #(
    parameter int WORDS = 100,
    parameter int IDX_W = 7,
    parameter int CNT_W = 7
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WORDS-1:0] tags,
    input  logic             start,
    input  logic             abort,
    input  logic             idx_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] idx,
    output logic [WORDS-1:0] sel,
    output logic             busy,
    output logic             some,
    output logic [CNT_W-1:0] count,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t           state;
    logic [WORDS-1:0] pending;
    logic [WORDS-1:0] remain;

    // Lowest set bit wins: scan downward so the last hit is the smallest index.
    always_comb begin
        idx = '0;
        for (int i = WORDS - 1; i >= 0; i--)
            if (pending[i]) idx = IDX_W'(i);
    end

    // Isolating the lowest set bit equals 1<<idx and is zero when nothing is pending.
    assign sel    = pending & (~pending + WORDS'(1));
    assign remain = pending & ~sel;

    assign idx_valid = (state == ISSUE);
    assign busy      = (state == ISSUE);
    assign done      = (state == DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            pending <= '0;
            count   <= '0;
            some    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        pending <= tags;
                        count   <= '0;
                        some    <= |tags;
                        state   <= (|tags) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        pending <= '0;
                        state   <= IDLE;
                    end else if (idx_ready) begin
                        pending <= remain;
                        if (count != CNT_W'(WORDS)) count <= count + CNT_W'(1);
                        if (remain == '0) state <= DONE;
                    end
                end
                DONE: begin
                    pending <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    a_count_max: assert property (@(posedge CLK) disable iff (RST) count <= CNT_W'(WORDS));

endmodule

// File: tb/tb_tag_resolver.sv
// Bench for tag_resolver: table of passes plus abort/reset sequences; a queue
// of expected indices is filled at start and drained on each handshake.
module tb_tag_resolver;
    localparam int W = 100;

    logic         CLK, RST;
    logic [W-1:0] tags;
    logic         start, abort, idx_ready;
    logic         idx_valid, busy, some, done;
    logic [6:0]   idx;
    logic [W-1:0] sel;
    logic [6:0]   count;

    tag_resolver #(.WORDS(W), .IDX_W(7), .CNT_W(7)) dut (
        .CLK(CLK), .RST(RST), .tags(tags), .start(start), .abort(abort),
        .idx_ready(idx_ready), .idx_valid(idx_valid), .idx(idx), .sel(sel),
        .busy(busy), .some(some), .count(count), .done(done)
    );

    typedef struct {
        logic [W-1:0] tags;
        logic [W-1:0] tags_after;
        int           hold_idx;
        int           hold_n;
        bit           start_mid;
        int           exp_count;
        bit           exp_some;
    } vec_t;

    vec_t         vt[7];
    int           expq[$];
    int           checks = 0;
    int           failures = 0;
    int           done_cnt = 0;
    logic [W-1:0] one_w;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Handshake monitor: every accepted index must be the next expected one.
    always @(negedge CLK) begin
        if (!RST) begin
            if (done) done_cnt++;
            if (idx_valid) begin
                chk("sel_onehot", sel, one_w << idx);
                if (idx_ready) begin
                    if (expq.size() == 0) chk("unexpected_idx", {121'd0, idx}, 128'hFFFF);
                    else chk("idx_seq", {121'd0, idx}, expq.pop_front());
                end
            end
        end
    end

    task automatic run_pass(input vec_t v);
        int cyc, issue, stall, n, cnt0;
        n = 0; cnt0 = done_cnt;
        tags = v.tags; start = 1'b1; idx_ready = 1'b1;
        for (int i = 0; i < W; i++)
            if (v.tags[i]) begin expq.push_back(i); n++; end
        @(posedge CLK); #1;
        start = 1'b0; tags = v.tags_after;
        cyc = 0; issue = 0; stall = 0;
        while (!done && cyc < 400) begin
            idx_ready = 1'b1;
            start = (v.start_mid && cyc == 1);
            if (idx_valid) begin
                issue++;
                if (int'(idx) == v.hold_idx && stall < v.hold_n) begin
                    idx_ready = 1'b0;
                    stall++;
                end
            end
            @(posedge CLK); #1; cyc++;
        end
        start = 1'b0;
        chk("pass_done_seen", done, 1);
        chk("done_latency", cyc, issue);
        chk("issue_cycles", issue, n + v.hold_n);
        chk("stall_cycles", stall, v.hold_n);
        chk("count", count, v.exp_count);
        chk("some", some, v.exp_some);
        chk("queue_drained", expq.size(), 0);
        @(posedge CLK); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", idx_valid, 0);
        chk("done_pulses", done_cnt, cnt0 + 1);
        chk("count_holds", count, v.exp_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        one_w = '0; one_w[0] = 1'b1;
        RST = 1'b1; tags = '0; start = 0; abort = 0; idx_ready = 0;

        vt[0] = '{'0, '0, -1, 0, 0, 0, 0};
        vt[1] = '{(one_w << 3) | (one_w << 17) | (one_w << 99), '0, -1, 0, 0, 3, 1};
        vt[2] = '{(one_w << 3) | (one_w << 17) | (one_w << 99), '0, 17, 4, 0, 3, 1};
        vt[3] = '{'1, '0, -1, 0, 0, 100, 1};
        vt[4] = '{one_w << 99, '0, -1, 0, 0, 1, 1};
        vt[5] = '{one_w, '0, 0, 2, 0, 1, 1};
        vt[6] = '{(one_w << 3) | (one_w << 17) | (one_w << 99), '1, -1, 0, 1, 3, 1};

        #12;
        chk("rst_valid", idx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_some", some, 0);
        chk("rst_idx", idx, 0);
        chk("rst_sel", sel, 0);
        @(posedge CLK); #1; RST = 1'b0;

        for (int k = 0; k < 7; k++) run_pass(vt[k]);

        // Abort on index 6 together with ready: 5 counted, 6 not, no done.
        begin
            int cnt0;
            tags = (one_w << 5) | (one_w << 6);
            expq.push_back(5); expq.push_back(6);
            start = 1'b1; idx_ready = 1'b1;
            @(posedge CLK); #1; start = 1'b0;
            chk("ab_idx5", idx, 5);
            @(posedge CLK); #1;
            chk("ab_idx6", idx, 6);
            chk("ab_valid6", idx_valid, 1);
            cnt0 = done_cnt; abort = 1'b1;
            @(posedge CLK); #1; abort = 1'b0;
            chk("ab_valid", idx_valid, 0);
            chk("ab_busy", busy, 0);
            chk("ab_count", count, 1);
            chk("ab_some", some, 1);
            repeat (3) @(posedge CLK);
            #1;
            chk("ab_no_done", done_cnt, cnt0);
            chk("ab_queue", expq.size(), 0);
            start = 1'b1; abort = 1'b1;
            @(posedge CLK); #1; start = 1'b0; abort = 1'b0;
            chk("ab_wins_start", busy, 0);
            chk("ab_wins_done", done, 0);
        end

        // Asynchronous reset in the middle of a pass.
        tags = '1; start = 1'b1; idx_ready = 1'b1;
        for (int i = 0; i < W; i++) expq.push_back(i);
        @(posedge CLK); #1; start = 1'b0;
        repeat (5) @(posedge CLK);
        #2;
        chk("pre_rst_valid", idx_valid, 1);
        RST = 1'b1; #1;
        chk("arst_valid", idx_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sel", sel, 0);
        chk("arst_idx", idx, 0);
        chk("arst_count", count, 0);
        chk("arst_some", some, 0);
        expq.delete();
        @(posedge CLK); #1; RST = 1'b0;
        run_pass(vt[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tag_resolver.md
Name: tag_resolver

Overview:
- Multiple-response resolver. It reads the 100-bit tag register of the CAPP word array and hands out the indices of the set tags one at a time, lowest index first.
- Each index is offered on a valid/ready interface, together with a one-hot word select for the array read/write path.
- It sits downstream of the tag register and is the consumer of the tags that the tag register produces.

Parameters:
- WORDS, 100, number of CAPP words (tag width).
- IDX_W, 7, index width; must satisfy 2^IDX_W >= WORDS.
- CNT_W, 7, responder-count width; must hold the value WORDS.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- tags  input  WORDS  tag vector from the tag register.
- start  input  1  begin a resolve pass; sampled in IDLE only.
- abort  input  1  cancel the pass in progress.
- idx_ready  input  1  consumer accepts the current index.
- idx_valid  output  1  idx and sel are valid.
- idx  output  IDX_W  index of the current responder.
- sel  output  WORDS  one-hot select of the current responder.
- busy  output  1  a pass is in progress (state ISSUE).
- some  output  1  the snapshot at start had at least one tag set.
- count  output  CNT_W  responders accepted in this pass.
- done  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (asynchronous, RST=1):
  - state=IDLE, pending=0, count=0, some=0, done=0.
  - idx_valid=0, idx=0, sel=0, busy=0.
- State encoding: IDLE, ISSUE, DONE.
- IDLE:
  - On an edge with start=1: pending<=tags (snapshot), count<=0, some<=|tags.
  - If tags!=0, next state is ISSUE; otherwise next state is DONE.
  - tags changing after the snapshot edge has no effect on the pass.
- ISSUE:
  - idx_valid=1 and busy=1.
  - idx is the lowest set bit position of pending (priority encode from bit 0). sel=1<<idx.
  - idx and sel are combinational from pending and stay stable while idx_ready=0. Holding idx_valid low on backpressure is not allowed.
  - On an edge with idx_ready=1: clear bit idx in pending and increment count.
  - If the cleared pending is 0, go to DONE; otherwise stay in ISSUE, and the next index appears in the following cycle.
  - Throughput: one index per cycle while idx_ready is held at 1.
- DONE:
  - done=1 for exactly one cycle, then unconditionally return to IDLE.
  - some and count hold their values until the next start or reset.
- Latency:
  - start sampled at edge k gives the first idx_valid in the cycle after edge k.
  - With N responders and idx_ready held at 1, the pass lasts N ISSUE cycles, then one DONE cycle.
- abort:
  - Active in ISSUE or DONE: at the next edge, go to IDLE and clear pending.
  - done is not pulsed; count keeps its partial value.
  - abort has priority over idx_ready on the same edge: that index is not counted.
  - abort in IDLE is ignored, and abort wins over start on the same edge.
- start while busy or in DONE: ignored, with no queueing.
- Bit WORDS-1 is a valid responder: idx=WORDS-1 and sel has only its MSB set.
- Indices are never repeated or skipped within a pass.
- Reset mid-pass: immediate return to the reset values, including idx_valid=0 without waiting for a clock edge.
- count saturates: it cannot exceed WORDS by construction. Assertion: count <= WORDS.

Test Plan:
- Reset mid-ISSUE with idx_valid=1 -> outputs drop to the reset values asynchronously; after release, state is IDLE and a new start works normally.
- tags=0, start pulse -> no idx_valid; done pulses in the cycle after start; some=0, count=0.
- tags bits {3,17,99} set, idx_ready=1 throughout -> idx sequence 3,17,99 on three consecutive cycles; sel=1<<idx each cycle; done in the next cycle; some=1, count=3.
- Same tags with idx_ready low for 4 cycles on index 17 -> idx=17 and sel held stable for all 4 cycles; sequence unchanged; count=3.
- All 100 tags set, ready=1 -> idx counts 0..99 with no gaps; pass lasts 100 ISSUE cycles plus 1 DONE cycle; count=100.
- tags {5,6}, abort asserted together with idx_ready on index 6 -> return to IDLE, done never pulses, count=1.
- tags changed during the pass, and start pulsed while busy -> the snapshot sequence is unaffected and no second pass starts.
